sign_extension: RTL and testbench



---
 rtl/cpu_pkg.sv | 18 +
 rtl/sign_ext_core.sv | 53 +++++
 rtl/sign_extension.sv | 71 +++++++
 tb/tb_sign_extension.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants and the immediate-extension mode encoding.
package cpu_pkg;

    // Datapath word width used as the default widened immediate width.
    localparam int DATA_W = 16;

    // Extension mode; the numeric values match the zeroExt control bit.
    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_mode_e;

    // Map the raw zeroExt control bit onto the mode encoding.
    function automatic ext_mode_e ext_mode_from_bit(input logic zero_ext);
        return zero_ext ? EXT_ZERO : EXT_SIGN;
    endfunction

endpackage : cpu_pkg

// File: rtl/sign_ext_core.sv
// Purely combinational immediate widening (sign or zero) with an optional
// left shift by one for branch offsets.
module sign_ext_core
    import cpu_pkg::*;
#(
    parameter int N = 8,
    parameter int W = DATA_W
) (
    input  logic [N-1:0] data_i,
    input  ext_mode_e    mode_i,
    input  logic         shift_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] ext;

    generate
        if (N >= W) begin : g_pass
            // Field already fills the word: mode has nothing to fill.
            logic mode_unused;

            // Pass the field straight through; the mode input is ignored.
            always_comb begin
                mode_unused = (mode_i == EXT_ZERO);
                ext         = data_i[W-1:0];
            end
        end else begin : g_widen
            // Low bits carry the field, upper bits replicate its MSB or stay 0.
            always_comb begin
                ext        = '0;
                ext[N-1:0] = data_i;
                if (mode_i == EXT_SIGN) begin
                    ext[W-1:N] = {(W-N){data_i[N-1]}};
                end
            end
        end
    endgenerate

    generate
        if (W == 1) begin : g_shift_w1
            // A one-bit word shifted left leaves only the inserted zero.
            always_comb begin
                data_o = shift_i ? 1'b0 : ext;
            end
        end else begin : g_shift
            // Optional shift-by-one; the extended MSB falls off the top.
            always_comb begin
                data_o = shift_i ? {ext[W-2:0], 1'b0} : ext;
            end
        end
    endgenerate

endmodule : sign_ext_core

// File: rtl/sign_extension.sv
// Immediate-extension unit: combinational widened value plus a registered
// copy and valid flag for the pipeline stage boundary.
module sign_extension
    import cpu_pkg::*;
#(
    parameter int N = 8,
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] dataIn,
    input  logic         zeroExt,
    input  logic         shiftEn,
    input  logic         inValid,
    output logic [W-1:0] dataOut,
    output logic [W-1:0] dataOutReg,
    output logic         outValid,
    output logic         negative
);

    generate
        if (N < 1 || N > W) begin : g_bad_param
            $error("sign_extension: N=%0d must lie within 1..W (W=%0d)", N, W);
        end
    endgenerate

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;
    logic         valid_q;

    sign_ext_core #(
        .N(N),
        .W(W)
    ) u_core (
        .data_i (dataIn),
        .mode_i (ext_mode_from_bit(zeroExt)),
        .shift_i(shiftEn),
        .data_o (data_d)
    );

    // Combinational outputs follow the inputs regardless of clock or reset.
    always_comb begin
        dataOut  = data_d;
        negative = data_d[W-1];
    end

    // Capture the widened value only when the input is qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (inValid) begin
            data_q <= data_d;
        end
    end

    // Valid flag is a plain one-cycle delay of inValid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= inValid;
        end
    end

    // Registered outputs.
    always_comb begin
        dataOutReg = data_q;
        outValid   = valid_q;
    end

endmodule : sign_extension

// File: tb/tb_sign_extension.sv
// Self-checking bench for sign_extension at N = 12, 8, 16 and 1 (W = 16).
module tb_sign_extension;

    localparam int NI = 4;
    localparam int NS [NI] = '{12, 8, 16, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        zeroExt;
    logic        shiftEn;
    logic        inValid;
    logic [11:0] din12;
    logic [7:0]  din8;
    logic [15:0] din16;
    logic [0:0]  din1;

    logic [15:0] dout [NI];
    logic [15:0] dreg [NI];
    logic        oval [NI];
    logic        neg  [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sign_extension #(.N(12), .W(16)) u12 (
        .clk(clk), .rst_n(rst_n), .dataIn(din12), .zeroExt(zeroExt), .shiftEn(shiftEn),
        .inValid(inValid), .dataOut(dout[0]), .dataOutReg(dreg[0]), .outValid(oval[0]),
        .negative(neg[0]));
    sign_extension #(.N(8), .W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .dataIn(din8), .zeroExt(zeroExt), .shiftEn(shiftEn),
        .inValid(inValid), .dataOut(dout[1]), .dataOutReg(dreg[1]), .outValid(oval[1]),
        .negative(neg[1]));
    sign_extension #(.N(16), .W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .dataIn(din16), .zeroExt(zeroExt), .shiftEn(shiftEn),
        .inValid(inValid), .dataOut(dout[2]), .dataOutReg(dreg[2]), .outValid(oval[2]),
        .negative(neg[2]));
    sign_extension #(.N(1), .W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .dataIn(din1), .zeroExt(zeroExt), .shiftEn(shiftEn),
        .inValid(inValid), .dataOut(dout[3]), .dataOutReg(dreg[3]), .outValid(oval[3]),
        .negative(neg[3]));

    // Reference: interpret the field as a signed or unsigned integer, double it
    // when shifting, then reduce modulo 2^16.
    function automatic logic [15:0] ref_ext(input int n, input logic [15:0] d,
                                            input bit z, input bit s);
        longint v;
        v = longint'(d) & ((longint'(1) << n) - 1);
        if (!z && (((v >> (n - 1)) & 1) == 1)) v = v - (longint'(1) << n);
        if (s) v = v * 2;
        return v[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_din(input logic [15:0] d);
        din12 = d[11:0];
        din8  = d[7:0];
        din16 = d;
        din1  = d[0:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          idx;
        logic [15:0] d;
        bit          z;
        bit          s;
        logic [15:0] exp;
        bit          neg;
    } vec_t;

    vec_t        tbl [$];
    logic [15:0] exp_reg [NI];
    bit          exp_val;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // idx: 0 -> N=12, 1 -> N=8, 2 -> N=16, 3 -> N=1
        tbl.push_back('{0, 16'h0001, 0, 0, 16'h0001, 0});
        tbl.push_back('{0, 16'h0002, 0, 0, 16'h0002, 0});
        tbl.push_back('{0, 16'h0FFF, 0, 0, 16'hFFFF, 1});
        tbl.push_back('{0, 16'h0800, 0, 0, 16'hF800, 1});
        tbl.push_back('{0, 16'h0800, 1, 0, 16'h0800, 0});
        tbl.push_back('{0, 16'h0FFF, 1, 0, 16'h0FFF, 0});
        tbl.push_back('{0, 16'h0800, 0, 1, 16'hF000, 1});
        tbl.push_back('{0, 16'h0001, 0, 1, 16'h0002, 0});
        tbl.push_back('{0, 16'h07FF, 0, 1, 16'h0FFE, 0});
        tbl.push_back('{0, 16'h0800, 1, 1, 16'h1000, 0});
        tbl.push_back('{1, 16'h0080, 0, 0, 16'hFF80, 1});
        tbl.push_back('{1, 16'h007F, 0, 0, 16'h007F, 0});
        tbl.push_back('{2, 16'h8000, 0, 0, 16'h8000, 1});
        tbl.push_back('{2, 16'h8000, 1, 0, 16'h8000, 1});
        tbl.push_back('{3, 16'h0001, 0, 0, 16'hFFFF, 1});
        tbl.push_back('{3, 16'h0001, 1, 0, 16'h0001, 0});
        tbl.push_back('{3, 16'h0000, 0, 0, 16'h0000, 0});

        rst_n = 1'b0; zeroExt = 1'b0; shiftEn = 1'b0; inValid = 1'b0;
        set_din(16'h0000);
        #2;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_reg[N=%0d]", NS[k]), 32'(dreg[k]), 32'h0);
            chk($sformatf("reset_valid[N=%0d]", NS[k]), 32'(oval[k]), 32'h0);
        end
        #10 rst_n = 1'b1;

        // Combinational table, each vector held 20 time units.
        foreach (tbl[i]) begin
            set_din(tbl[i].d);
            zeroExt = tbl[i].z;
            shiftEn = tbl[i].s;
            #20;
            chk($sformatf("tbl%0d_dataOut[N=%0d]", i, NS[tbl[i].idx]),
                32'(dout[tbl[i].idx]), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_negative[N=%0d]", i, NS[tbl[i].idx]),
                32'(neg[tbl[i].idx]), 32'(tbl[i].neg));
        end

        // Registered path on N=12, sign-extend, no shift.
        zeroExt = 1'b0; shiftEn = 1'b0;
        tick();
        set_din(16'h0FFF); inValid = 1'b1;
        tick();
        chk("reg_pulse_data", 32'(dreg[0]), 32'hFFFF);
        chk("reg_pulse_valid", 32'(oval[0]), 32'h1);
        inValid = 1'b0; set_din(16'h0123);
        tick();
        chk("reg_hold_data", 32'(dreg[0]), 32'hFFFF);
        chk("reg_hold_valid", 32'(oval[0]), 32'h0);
        inValid = 1'b1; set_din(16'h0001);
        tick();
        chk("b2b_1_data", 32'(dreg[0]), 32'h0001);
        chk("b2b_1_valid", 32'(oval[0]), 32'h1);
        set_din(16'h0002);
        tick();
        chk("b2b_2_data", 32'(dreg[0]), 32'h0002);
        set_din(16'h0803);
        tick();
        chk("b2b_3_data", 32'(dreg[0]), 32'hF803);
        chk("b2b_3_valid", 32'(oval[0]), 32'h1);
        inValid = 1'b0;
        tick();
        chk("b2b_end_valid", 32'(oval[0]), 32'h0);
        chk("b2b_end_data", 32'(dreg[0]), 32'hF803);

        // Asynchronous reset mid-cycle while holding FFFF/valid.
        set_din(16'h0FFF); inValid = 1'b1;
        tick();
        chk("pre_rst_data", 32'(dreg[0]), 32'hFFFF);
        chk("pre_rst_valid", 32'(oval[0]), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(dreg[0]), 32'h0);
        chk("async_rst_valid", 32'(oval[0]), 32'h0);
        set_din(16'h0800);
        #1;
        chk("rst_comb_track", 32'(dout[0]), 32'hF800);
        tick();
        chk("rst_held_data", 32'(dreg[0]), 32'h0);
        chk("rst_held_valid", 32'(oval[0]), 32'h0);
        #2 rst_n = 1'b1;
        set_din(16'h0001); inValid = 1'b1;
        #1;
        chk("post_rel_pre_edge", 32'(dreg[0]), 32'h0);
        tick();
        chk("post_rel_data", 32'(dreg[0]), 32'h0001);
        chk("post_rel_valid", 32'(oval[0]), 32'h1);

        // Randomized run against the reference model, starting from reset.
        inValid = 1'b0;
        rst_n = 1'b0; #1 rst_n = 1'b1;
        for (int k = 0; k < NI; k++) exp_reg[k] = '0;
        exp_val = 1'b0;
        tick();
        for (int it = 0; it < 300; it++) begin
            logic [15:0] d;
            bit z, s, v;
            d = 16'($urandom);
            z = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 9) < 7);
            set_din(d); zeroExt = z; shiftEn = s; inValid = v;
            #1;
            for (int k = 0; k < NI; k++) begin
                logic [15:0] e;
                e = ref_ext(NS[k], d, z, s);
                chk($sformatf("rnd%0d_dataOut[N=%0d]", it, NS[k]), 32'(dout[k]), 32'(e));
                chk($sformatf("rnd%0d_negative[N=%0d]", it, NS[k]), 32'(neg[k]), 32'(e[15]));
                if (v) exp_reg[k] = e;
            end
            exp_val = v;
            tick();
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("rnd%0d_reg[N=%0d]", it, NS[k]), 32'(dreg[k]), 32'(exp_reg[k]));
                chk($sformatf("rnd%0d_valid[N=%0d]", it, NS[k]), 32'(oval[k]), 32'(exp_val));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sign_extension
